// File: rtl/timeout_sched_pkg.sv
// Shared types and sizing helpers for the multi-channel timeout scheduler.
package timeout_sched_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } sweep_state_t;

   localparam int CNT_W_DEF = 16;

   // Channel index width; a one-bit index is kept even for tiny channel counts.
   function automatic int idx_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/timeout_scheduler_if.sv
// Client-facing bundle of the timeout scheduler: tick, per-channel controls and status.
interface timeout_scheduler_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16
);
   logic                      tick_in;
   logic [NUM_CH-1:0]         arm;
   logic [NUM_CH*CNT_W-1:0]   arm_val;
   logic [NUM_CH-1:0]         stop;
   logic [NUM_CH-1:0]         exp_ack;
   logic [NUM_CH-1:0]         active;
   logic [NUM_CH-1:0]         expire;
   logic                      busy;
   logic                      ovr;

   modport master (
      output tick_in, arm, arm_val, stop, exp_ack,
      input  active, expire, busy, ovr
   );

   modport slave (
      input  tick_in, arm, arm_val, stop, exp_ack,
      output active, expire, busy, ovr
   );
endinterface

// File: rtl/tmo_sweep_ctrl.sv
// Sweep sequencer: walks idx 0..NUM_CH-1 once per tick, queues one extra tick, flags overrun.
module tmo_sweep_ctrl
   import timeout_sched_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int IDX_W  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   output logic             step_en,
   output logic [IDX_W-1:0] step_idx,
   output logic             busy,
   output logic             ovr
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

   sweep_state_t     state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             pend_q, pend_d;
   logic             ovr_q, ovr_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         pend_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pend_q  <= pend_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pend_d  = pend_q;
      ovr_d   = ovr_q;
      // Only one tick can be queued; a tick landing on a full queue is lost.
      if (tick && pend_q) begin
         ovr_d = 1'b1;
      end
      case (state_q)
         IDLE: begin
            if (tick || pend_q) begin
               state_d = SWEEP;
               idx_d   = '0;
               pend_d  = 1'b0;
            end
         end
         SWEEP: begin
            if (idx_q == LAST_IDX) begin
               idx_d  = '0;
               pend_d = 1'b0;
               // A tick on the final step chains straight into the next sweep.
               if (!(tick || pend_q)) begin
                  state_d = IDLE;
               end
            end else begin
               idx_d = idx_q + 1'b1;
               if (tick) begin
                  pend_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   assign step_en  = (state_q == SWEEP);
   assign step_idx = idx_q;
   assign busy     = (state_q == SWEEP);
   assign ovr      = ovr_q;

endmodule

// File: rtl/timeout_scheduler.sv
// Multi-channel ms timeout service: one shared decrementer swept across channels per tick.
module timeout_scheduler
   import timeout_sched_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   timeout_scheduler_if.slave  bus
);

   localparam int IDX_W = idx_width(NUM_CH);

   logic [CNT_W-1:0]  cnt_q [NUM_CH];
   logic [CNT_W-1:0]  cnt_d [NUM_CH];
   logic [NUM_CH-1:0] active_q, active_d;
   logic [NUM_CH-1:0] expire_q, expire_d;

   logic              step_en;
   logic [IDX_W-1:0]  step_idx;
   logic              sweep_busy;
   logic              sweep_ovr;

   logic [CNT_W-1:0]  sel_cnt;
   logic [CNT_W-1:0]  dec_val;
   logic              dec_en;
   logic              dec_last;

   tmo_sweep_ctrl #(
      .NUM_CH (NUM_CH),
      .IDX_W  (IDX_W)
   ) u_sweep (
      .clk      (clk),
      .rst      (rst),
      .tick     (bus.tick_in),
      .step_en  (step_en),
      .step_idx (step_idx),
      .busy     (sweep_busy),
      .ovr      (sweep_ovr)
   );

   // Shared decrement datapath; the zero guard keeps counts from wrapping.
   assign sel_cnt  = cnt_q[step_idx];
   assign dec_val  = sel_cnt - 1'b1;
   assign dec_last = (sel_cnt == CNT_W'(1));
   assign dec_en   = step_en && active_q[step_idx] && (sel_cnt != '0);

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i]    = cnt_q[i];
         active_d[i] = active_q[i];
         expire_d[i] = expire_q[i] & ~bus.exp_ack[i];
         if (bus.arm[i]) begin
            if (bus.arm_val[i*CNT_W +: CNT_W] == '0) begin
               active_d[i] = 1'b0;
               expire_d[i] = 1'b1;
            end else begin
               cnt_d[i]    = bus.arm_val[i*CNT_W +: CNT_W];
               active_d[i] = 1'b1;
            end
         end else if (bus.stop[i]) begin
            cnt_d[i]    = '0;
            active_d[i] = 1'b0;
         end else if (dec_en && (step_idx == IDX_W'(i))) begin
            cnt_d[i] = dec_val;
            if (dec_last) begin
               active_d[i] = 1'b0;
               expire_d[i] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '{default: '0};
         active_q <= '0;
         expire_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         active_q <= active_d;
         expire_q <= expire_d;
      end
   end

   assign bus.active = active_q;
   assign bus.expire = expire_q;
   assign bus.busy   = sweep_busy;
   assign bus.ovr    = sweep_ovr;

endmodule

// File: tb/tb_timeout_scheduler.sv
// Bench for timeout_scheduler: directed scenarios plus random traffic against a
// sweep-schedule reference model (ticks map to sweep windows, channel i hit at start+i).
module tb_timeout_scheduler;

   localparam int N = 4;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   timeout_scheduler_if #(.NUM_CH(N), .CNT_W(W)) bus ();

   timeout_scheduler #(.NUM_CH(N), .CNT_W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: sweeps are time windows [start, start+N-1].
   int m_cnt [N];
   bit m_act [N];
   bit m_exp [N];
   bit m_ovr = 1'b0;
   bit m_busy = 1'b0;
   int starts[$];
   int last_start = -10;
   int last_end   = -10;
   int cyc = 0;

   always @(posedge clk) begin : model
      int idx;
      int av;
      bit set;
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0;
            m_act[i] = 1'b0;
            m_exp[i] = 1'b0;
         end
         m_ovr = 1'b0;
         starts.delete();
         last_start = -10;
         last_end   = -10;
      end else begin
         idx = -1;
         foreach (starts[k]) begin
            if (cyc >= starts[k] && cyc < starts[k] + N) idx = cyc - starts[k];
         end
         if (bus.tick_in === 1'b1) begin
            if (cyc > last_end) begin
               last_start = cyc + 1;
               last_end   = cyc + N;
               starts.push_back(last_start);
            end else if (last_start > cyc) begin
               m_ovr = 1'b1;
            end else begin
               last_start = last_end + 1;
               last_end   = last_end + N;
               starts.push_back(last_start);
            end
         end
         for (int i = 0; i < N; i++) begin
            set = 1'b0;
            av  = int'(bus.arm_val[i*W +: W]);
            if (bus.arm[i]) begin
               if (av == 0) begin
                  m_act[i] = 1'b0;
                  set = 1'b1;
               end else begin
                  m_cnt[i] = av;
                  m_act[i] = 1'b1;
               end
            end else if (bus.stop[i]) begin
               m_act[i] = 1'b0;
               m_cnt[i] = 0;
            end else if (idx == i && m_act[i]) begin
               m_cnt[i] = m_cnt[i] - 1;
               if (m_cnt[i] == 0) begin
                  m_act[i] = 1'b0;
                  set = 1'b1;
               end
            end
            if (set) m_exp[i] = 1'b1;
            else if (bus.exp_ack[i]) m_exp[i] = 1'b0;
         end
         while (starts.size() > 0 && starts[0] + N <= cyc) void'(starts.pop_front());
      end
      cyc++;
      m_busy = 1'b0;
      foreach (starts[k]) begin
         if (cyc >= starts[k] && cyc < starts[k] + N) m_busy = 1'b1;
      end
   end

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_now();
      bus.tick_in = 1'b1;
      next();
      bus.tick_in = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      next();
      next();
      @(negedge clk);
      n_checks++;
      if (bus.active !== 4'b0000) $display("FAIL reset_active: got %b want 0000", bus.active);
      else n_pass++;
      n_checks++;
      if (bus.expire !== 4'b0000) $display("FAIL reset_expire: got %b want 0000", bus.expire);
      else n_pass++;
      n_checks++;
      if (bus.busy !== 1'b0 || bus.ovr !== 1'b0)
         $display("FAIL reset_busy_ovr: got %b%b want 00", bus.busy, bus.ovr);
      else n_pass++;
      next();
      rst = 1'b0;
      next();
   endtask

   task automatic test_expiry_basic();
      bus.arm[0] = 1'b1;
      bus.arm_val[0 +: W] = 16'd3;
      next();
      bus.arm[0] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         repeat (49) next();
         tick_now();
      end
      @(negedge clk);
      n_checks++;
      if (bus.expire[0] !== 1'b0 || bus.active[0] !== 1'b1)
         $display("FAIL t1_before: got exp=%b act=%b want exp=0 act=1", bus.expire[0], bus.active[0]);
      else n_pass++;
      next();
      @(negedge clk);
      n_checks++;
      if (bus.expire[0] !== 1'b1 || bus.active[0] !== 1'b0)
         $display("FAIL t1_expire: got exp=%b act=%b want exp=1 act=0", bus.expire[0], bus.active[0]);
      else n_pass++;
      bus.exp_ack[0] = 1'b1;
      next();
      bus.exp_ack[0] = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.expire[0] !== 1'b0) $display("FAIL t1_ack: got %b want 0", bus.expire[0]);
      else n_pass++;
      repeat (6) next();
   endtask

   task automatic test_ack_collision();
      bus.arm[2] = 1'b1;
      bus.arm_val[2*W +: W] = 16'd1;
      next();
      bus.arm[2] = 1'b0;
      repeat (2) next();
      tick_now();
      next();
      next();
      @(negedge clk);
      n_checks++;
      if (bus.expire[2] !== 1'b0) $display("FAIL t2_early: got %b want 0", bus.expire[2]);
      else n_pass++;
      bus.exp_ack[2] = 1'b1;
      next();
      @(negedge clk);
      n_checks++;
      if (bus.expire[2] !== 1'b1) $display("FAIL t2_set_wins: got %b want 1", bus.expire[2]);
      else n_pass++;
      next();
      bus.exp_ack[2] = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.expire[2] !== 1'b0) $display("FAIL t2_acked: got %b want 0", bus.expire[2]);
      else n_pass++;
      repeat (4) next();
   endtask

   task automatic test_stop_and_zero_arm();
      bus.arm[1] = 1'b1;
      bus.arm_val[1*W +: W] = 16'd5;
      next();
      bus.arm[1] = 1'b0;
      tick_now();
      repeat (10) next();
      tick_now();
      repeat (10) next();
      bus.stop[1] = 1'b1;
      next();
      bus.stop[1] = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.active[1] !== 1'b0) $display("FAIL t3_stop_active: got %b want 0", bus.active[1]);
      else n_pass++;
      for (int k = 0; k < 6; k++) begin
         tick_now();
         repeat (8) next();
      end
      @(negedge clk);
      n_checks++;
      if (bus.expire[1] !== 1'b0) $display("FAIL t3_no_expire: got %b want 0", bus.expire[1]);
      else n_pass++;
      bus.arm[1] = 1'b1;
      bus.arm_val[1*W +: W] = 16'd0;
      next();
      bus.arm[1] = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.expire[1] !== 1'b1 || bus.active[1] !== 1'b0)
         $display("FAIL t3_zero_arm: got exp=%b act=%b want exp=1 act=0", bus.expire[1], bus.active[1]);
      else n_pass++;
      bus.exp_ack[1] = 1'b1;
      next();
      bus.exp_ack[1] = 1'b0;
      next();
   endtask

   task automatic test_arm_during_sweep();
      bus.arm[3] = 1'b1;
      bus.arm_val[3*W +: W] = 16'd1;
      next();
      bus.arm[3] = 1'b0;
      tick_now();
      repeat (3) next();
      @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b1) $display("FAIL t4_in_sweep: got busy=%b want 1", bus.busy);
      else n_pass++;
      bus.arm[3] = 1'b1;
      bus.arm_val[3*W +: W] = 16'd2;
      next();
      bus.arm[3] = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.active[3] !== 1'b1 || bus.expire[3] !== 1'b0)
         $display("FAIL t4_reload: got act=%b exp=%b want act=1 exp=0", bus.active[3], bus.expire[3]);
      else n_pass++;
      repeat (5) next();
      tick_now();
      repeat (6) next();
      @(negedge clk);
      n_checks++;
      if (bus.active[3] !== 1'b1 || bus.expire[3] !== 1'b0)
         $display("FAIL t4_first_tick: got act=%b exp=%b want act=1 exp=0", bus.active[3], bus.expire[3]);
      else n_pass++;
      tick_now();
      repeat (6) next();
      @(negedge clk);
      n_checks++;
      if (bus.active[3] !== 1'b0 || bus.expire[3] !== 1'b1)
         $display("FAIL t4_second_tick: got act=%b exp=%b want act=0 exp=1", bus.active[3], bus.expire[3]);
      else n_pass++;
      bus.exp_ack[3] = 1'b1;
      next();
      bus.exp_ack[3] = 1'b0;
      next();
   endtask

   task automatic test_back_to_back();
      int busy_cnt;
      busy_cnt = 0;
      tick_now();
      for (int k = 1; k <= 10; k++) begin
         bus.tick_in = (k == 2 || k == 3);
         @(negedge clk);
         if (bus.busy === 1'b1) busy_cnt++;
         next();
      end
      bus.tick_in = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy_cnt !== 8) $display("FAIL t5_busy_len: got %0d want 8", busy_cnt);
      else n_pass++;
      n_checks++;
      if (bus.ovr !== 1'b1) $display("FAIL t5_ovr: got %b want 1", bus.ovr);
      else n_pass++;
      n_checks++;
      if (bus.busy !== 1'b0) $display("FAIL t5_idle: got %b want 0", bus.busy);
      else n_pass++;
      repeat (3) next();
   endtask

   task automatic test_reset_mid_sweep();
      bus.arm[0] = 1'b1;
      bus.arm_val[0 +: W] = 16'd1;
      bus.arm[2] = 1'b1;
      bus.arm_val[2*W +: W] = 16'd1;
      next();
      bus.arm = '0;
      tick_now();
      rst = 1'b1;
      next();
      @(negedge clk);
      n_checks++;
      if (bus.active !== 4'b0000 || bus.expire !== 4'b0000)
         $display("FAIL t6_rst_chan: got act=%b exp=%b want 0000 0000", bus.active, bus.expire);
      else n_pass++;
      n_checks++;
      if (bus.busy !== 1'b0 || bus.ovr !== 1'b0)
         $display("FAIL t6_rst_ctrl: got busy=%b ovr=%b want 0 0", bus.busy, bus.ovr);
      else n_pass++;
      rst = 1'b0;
      repeat (20) next();
      tick_now();
      repeat (10) next();
      @(negedge clk);
      n_checks++;
      if (bus.expire !== 4'b0000) $display("FAIL t6_no_expire: got %b want 0000", bus.expire);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [N-1:0] e_act, e_exp;
      int bad;
      bad = 0;
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 599) == 0);
         bus.tick_in = ($urandom_range(0, 5) == 0);
         for (int i = 0; i < N; i++) begin
            bus.arm[i] = ($urandom_range(0, 11) == 0);
            bus.arm_val[i*W +: W] = W'($urandom_range(0, 4));
            bus.stop[i] = ($urandom_range(0, 15) == 0);
            bus.exp_ack[i] = ($urandom_range(0, 3) == 0);
         end
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            e_act[i] = m_act[i];
            e_exp[i] = m_exp[i];
         end
         n_checks++;
         if (bus.active !== e_act) begin
            if (bad < 10) $display("FAIL rnd_active cyc=%0d: got %b want %b", cyc, bus.active, e_act);
            bad++;
         end else n_pass++;
         n_checks++;
         if (bus.expire !== e_exp) begin
            if (bad < 10) $display("FAIL rnd_expire cyc=%0d: got %b want %b", cyc, bus.expire, e_exp);
            bad++;
         end else n_pass++;
         n_checks++;
         if (bus.busy !== m_busy) begin
            if (bad < 10) $display("FAIL rnd_busy cyc=%0d: got %b want %b", cyc, bus.busy, m_busy);
            bad++;
         end else n_pass++;
         n_checks++;
         if (bus.ovr !== m_ovr) begin
            if (bad < 10) $display("FAIL rnd_ovr cyc=%0d: got %b want %b", cyc, bus.ovr, m_ovr);
            bad++;
         end else n_pass++;
         next();
      end
      rst = 1'b0;
      bus.tick_in = 1'b0;
      bus.arm = '0;
      bus.stop = '0;
      bus.exp_ack = '0;
   endtask

   initial begin
      bus.tick_in = 1'b0;
      bus.arm     = '0;
      bus.arm_val = '0;
      bus.stop    = '0;
      bus.exp_ack = '0;
      test_reset();
      test_expiry_basic();
      test_ack_collision();
      test_stop_and_zero_arm();
      test_arm_during_sweep();
      test_back_to_back();
      test_reset_mid_sweep();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
